// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared link configuration: word width, SPI modes, sample-edge mapping
package config_pkg;

    localparam int P_DATA_WIDTH = 8;

    // Encoding is {CPOL, CPHA}, so the mode number matches the usual SPI numbering.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    function automatic spi_mode_t mode_of(input int cpol, input int cpha);
        return spi_mode_t'({cpol[0], cpha[0]});
    endfunction

    // Rising-edge sampling whenever CPOL and CPHA agree.
    function automatic logic sample_on_rising(input spi_mode_t mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_receiver_if.sv
// rtl/spi_receiver_if.sv - received-word valid/ready port plus error pulses
interface spi_receiver_if #(
    parameter int P_DATA_WIDTH = config_pkg::P_DATA_WIDTH
);
    logic                    ready;
    logic                    valid;
    logic [P_DATA_WIDTH-1:0] data;
    logic                    frame_err;
    logic                    overrun;

    modport master (
        input  ready,
        output valid,
        output data,
        output frame_err,
        output overrun
    );

    modport slave (
        output ready,
        input  valid,
        input  data,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - N-stage pin synchronizer with registered rise/fall detection
module sync_edge #(
    parameter int   P_STAGES    = 2,
    parameter logic P_RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [P_STAGES-1:0] chain;
    logic                hist;

    // level is taken from the history flop so it lines up with the registered edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {P_STAGES{P_RESET_VAL}};
            hist  <= P_RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[P_STAGES-2:0], din};
            hist  <= chain[P_STAGES-1];
            rise  <= chain[P_STAGES-1] & ~hist;
            fall  <= ~chain[P_STAGES-1] & hist;
        end
    end

    assign level = hist;

endmodule

// File: rtl/spi_receiver.sv
// rtl/spi_receiver.sv - oversampling SPI slave receiver, MSB-first words on a valid/ready port
module spi_receiver
    import config_pkg::*;
#(
    parameter int P_DATA_WIDTH  = config_pkg::P_DATA_WIDTH,
    parameter int P_CPOL        = 0,
    parameter int P_CPHA        = 0,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic           clk_100,
    input  logic           a_rst,
    input  logic           SCK,
    input  logic           CS,
    input  logic           MOSI,
    spi_receiver_if.master rx
);

    localparam int        CW          = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST    = CW'(P_DATA_WIDTH - 1);
    localparam spi_mode_t MODE        = mode_of(P_CPOL, P_CPHA);
    localparam logic      SAMPLE_RISE = sample_on_rising(MODE);

    logic sck_rise, sck_fall, sck_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.P_STAGES(P_SYNC_STAGES), .P_RESET_VAL(P_CPOL[0])) u_sync_sck (
        .clk(clk_100), .rst(a_rst), .din(SCK),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.P_STAGES(P_SYNC_STAGES), .P_RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk_100), .rst(a_rst), .din(CS),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.P_STAGES(P_SYNC_STAGES), .P_RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk_100), .rst(a_rst), .din(MOSI),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    rx_state_t               state, next_state;
    logic [P_DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]           bitcnt;
    logic                    sample_edge;
    logic                    shift_en;
    logic                    word_done;
    logic                    abort;
    logic [P_DATA_WIDTH-1:0] word_next;

    logic                    valid_q;
    logic [P_DATA_WIDTH-1:0] data_q;
    logic                    frame_err_q;
    logic                    overrun_q;

    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign word_next   = {shreg[P_DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (cs_fall) next_state = ST_SHIFT;
            ST_SHIFT: if (cs_rise) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // A CS release wins over a coincident sample edge; the input timing keeps them apart anyway.
    always_comb begin
        shift_en  = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        if (state == ST_SHIFT) begin
            shift_en  = sample_edge && !cs_rise;
            word_done = sample_edge && !cs_rise && (bitcnt == LAST);
            abort     = cs_rise && (bitcnt != '0);
        end
    end

    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (next_state == ST_IDLE) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (shift_en) begin
            shreg  <= word_next;
            bitcnt <= word_done ? '0 : bitcnt + CW'(1);
        end
    end

    // A completion with a pending unaccepted word is dropped; the held word is never overwritten.
    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= abort;
            overrun_q   <= word_done && valid_q && !rx.ready;
            if (word_done) begin
                if (!valid_q || rx.ready) begin
                    data_q  <= word_next;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && rx.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.valid     = valid_q;
    assign rx.data      = data_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;

endmodule

// File: doc/spi_receiver.md
# spi_receiver

SPI slave-side receiver for the serial link driven by the `transmitter` block. It operates entirely in the `clk_100` domain and oversamples `SCK`, `CS` and `MOSI` through synchronizers. Bits are shifted in MSB-first, and each completed `P_DATA_WIDTH`-bit word is presented on a valid/ready output. It closes the loop on the transmit path, used both for loopback self-test of `transmitter` and on the far-end board.

## Interface
Parameters:
- `P_DATA_WIDTH`, default `config_pkg::P_DATA_WIDTH`: word length in bits.
- `P_CPOL`, default 0: SCK idle level.
- `P_CPHA`, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
- `P_SYNC_STAGES`, default 2 (legal ≥ 2): synchronizer depth on each input pin.

Ports:
- `clk_100`  in  1: system clock, 100 MHz.
- `a_rst`  in  1: reset, asynchronous, active-high.
- `SCK`  in  1: serial clock from the master, asynchronous to `clk_100`.
- `CS`  in  1: chip select, active-low, asynchronous.
- `MOSI`  in  1: serial data, asynchronous.
- `ready`  in  1: downstream can accept a word.
- `valid`  out  1: `data` holds an unconsumed word.
- `data`  out  `P_DATA_WIDTH`: received word, MSB = first bit on the wire.
- `frame_err`  out  1: one-cycle pulse when CS is released mid-word.
- `overrun`  out  1: one-cycle pulse when a completed word is dropped.

## Operation
- All three pins pass through `P_SYNC_STAGES` flops, then one history flop for edge detection.
- The sample edge is rising when `P_CPOL == P_CPHA`, and falling otherwise.
- States:
  - IDLE: synchronized CS = 1. Shift register and bit counter are held at 0. SCK edges are ignored.
  - IDLE → SHIFT on synchronized CS falling.
  - SHIFT: on each detected sample edge, `shreg <= {shreg[W-2:0], MOSI_sync}` and `bitcnt++`.
  - When `bitcnt` reaches `P_DATA_WIDTH-1` and a sample edge occurs, the word is complete. `bitcnt` wraps to 0 and SHIFT continues, so back-to-back words under one CS assertion are legal.
  - SHIFT → IDLE on synchronized CS rising. If `bitcnt != 0`, pulse `frame_err` and discard the partial word.
- Word completion while `valid = 0`: load `data`, set `valid`.
- Word completion while `valid = 1 && ready = 1` in the same cycle: handshake consumes the old word, the new word loads, and `valid` stays 1.
- Word completion while `valid = 1 && ready = 0`: new word dropped, `data` unchanged, pulse `overrun`.
- `valid && ready` with no completion: clear `valid`. `data` keeps its last value.
- CS release never affects a word already in `data`.
- Reset values:
  - `valid`, `frame_err`, `overrun` = 0; `data` = 0; state = IDLE.
  - Synchronizers reset to idle pin levels: SCK = `P_CPOL`, CS = 1, MOSI = 0.

## Timing
- Input constraint: SCK high and low phases each ≥ 4 `clk_100` cycles (SCK ≤ 12.5 MHz). CS setup/hold to the first/last SCK edge ≥ 4 cycles. MOSI stable ≥ 4 cycles around the sample edge.
- Latency: `valid` rises exactly `P_SYNC_STAGES + 1` `clk_100` cycles after the cycle in which synchronizer stage 1 first captures the final sample edge.
- `frame_err` pulses `P_SYNC_STAGES + 1` cycles after stage 1 captures CS high.
- `data` and `valid` are registered outputs with no combinational path from `ready`.
- Throughput: one word per `P_DATA_WIDTH` SCK periods, with no dead cycles between words.

## Structure
- `config_pkg` owns `P_DATA_WIDTH` and a new `spi_mode_t` enum {MODE0..MODE3}. The package also provides a function mapping mode to sample-edge polarity; `transmitter` uses the same function.
- Sub-module `sync_edge`: parameterized N-stage synchronizer with rise/fall outputs. It is instantiated three times (SCK, CS, MOSI; edge outputs unused on MOSI).
- The FSM, bit counter and output register live in `spi_receiver`.

## Test plan
All scenarios use `P_DATA_WIDTH` = 8 and SCK = `clk_100`/16.
- Mode 0, `ready` = 1, CS low, send 0xA5 → `valid` for exactly 1 cycle with `data` = 0xA5, `P_SYNC_STAGES`+1 cycles after the 8th rising SCK; no `frame_err`/`overrun`.
- All four modes, one CS frame carrying 0x3C, 0xC3 → two words in order, `data` = 0x3C then 0xC3.
- `ready` = 0, send 0x11 then 0x22 → `data` = 0x11 held with `valid` = 1; one `overrun` pulse at the second completion; raising `ready` consumes 0x11 and `valid` drops.
- `ready` asserted on the exact cycle 0x22 completes while 0x11 is pending → 0x11 handshaken, `data` = 0x22, `valid` continuous, no `overrun`.
- CS released after 5 bits of 0xFF, then a full 0x81 → one `frame_err` pulse, no word for the partial, next word = 0x81 (counter restarted).
- `a_rst` pulsed mid-word with 4 bits shifted → outputs at reset values immediately; SCK toggling while CS high gives no `valid`; next full frame 0x5A received correctly.
